// File: rtl/dmem_bus_bridge_if.sv
// Request/response and 32-bit data-bus signals of the memory-stage bridge.
// The bridge takes the master view; the datapath plus memory take the slave view.
interface dmem_bus_bridge_if;
    logic        iReq;
    logic        iWrite;
    logic [1:0]  iSize;
    logic        iSigned;
    logic [31:0] iAddr;
    logic [63:0] iWData;
    logic        oBusy;
    logic        oDone;
    logic        oMisalign;
    logic [63:0] oRData;
    logic        DwReadEnable;
    logic        DwWriteEnable;
    logic [3:0]  DwByteEnable;
    logic [31:0] DwAddress;
    logic [31:0] DwWriteData;
    logic [31:0] DwReadData;

    modport master (
        input  iReq, iWrite, iSize, iSigned, iAddr, iWData, DwReadData,
        output oBusy, oDone, oMisalign, oRData,
        output DwReadEnable, DwWriteEnable, DwByteEnable, DwAddress, DwWriteData
    );

    modport slave (
        output iReq, iWrite, iSize, iSigned, iAddr, iWData, DwReadData,
        input  oBusy, oDone, oMisalign, oRData,
        input  DwReadEnable, DwWriteEnable, DwByteEnable, DwAddress, DwWriteData
    );
endinterface

// File: rtl/dmem_bus_bridge.sv
// LEGv8 load/store bridge onto a 32-bit data bus: lane steering, dword split into two
// beats (low word first), load extension and a one-cycle completion pulse.
module dmem_bus_bridge #(
    parameter int unsigned READ_LAT = 1
) (
    input logic               iCLK,
    input logic               iRST,
    dmem_bus_bridge_if.master bus
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    localparam logic [1:0] LastCnt = 2'(READ_LAT - 1);

    state_e      state_q, state_d;
    logic        write_q, write_d;
    logic [1:0]  size_q, size_d;
    logic        signed_q, signed_d;
    logic [31:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic        beat_q, beat_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] lo_q, lo_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        misalign_q, misalign_d;
    logic [63:0] rdata_q, rdata_d;
    logic        re_q, re_d;
    logic        we_q, we_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] baddr_q, baddr_d;
    logic [31:0] bwdata_q, bwdata_d;

    function automatic logic is_misaligned(logic [1:0] size, logic [2:0] a);
        case (size)
            2'd1:    return a[0];
            2'd2:    return |a[1:0];
            2'd3:    return |a[2:0];
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] lane_be(logic [1:0] size, logic [1:0] a);
        case (size)
            2'd0:    return 4'b0001 << a;
            2'd1:    return a[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_data(logic [1:0] size, logic [31:0] wd);
        case (size)
            2'd0:    return {4{wd[7:0]}};
            2'd1:    return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

    // Sub-dword loads only; alignment is already guaranteed, so shifting by addr[1:0] is safe.
    function automatic logic [63:0] load_extract(logic [1:0] size, logic sext, logic [1:0] a,
                                                 logic [31:0] rd);
        logic [31:0] sh;
        sh = rd >> {a, 3'b000};
        case (size)
            2'd0:    return sext ? {{56{sh[7]}}, sh[7:0]} : {56'd0, sh[7:0]};
            2'd1:    return sext ? {{48{sh[15]}}, sh[15:0]} : {48'd0, sh[15:0]};
            default: return sext ? {{32{sh[31]}}, sh} : {32'd0, sh};
        endcase
    endfunction

    always_comb begin
        state_d    = state_q;
        write_d    = write_q;
        size_d     = size_q;
        signed_d   = signed_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        beat_d     = beat_q;
        cnt_d      = cnt_q;
        lo_d       = lo_q;
        done_d     = 1'b0;
        misalign_d = 1'b0;
        rdata_d    = rdata_q;
        re_d       = 1'b0;
        we_d       = 1'b0;
        be_d       = 4'b0000;
        baddr_d    = baddr_q;
        bwdata_d   = bwdata_q;

        case (state_q)
            StIdle: begin
                if (bus.iReq) begin
                    write_d  = bus.iWrite;
                    size_d   = bus.iSize;
                    signed_d = bus.iSigned;
                    addr_d   = bus.iAddr;
                    wdata_d  = bus.iWData;
                    beat_d   = 1'b0;
                    if (is_misaligned(bus.iSize, bus.iAddr[2:0])) begin
                        state_d    = StResp;
                        done_d     = 1'b1;
                        misalign_d = 1'b1;
                        rdata_d    = 64'd0;
                    end else begin
                        state_d  = StIssue;
                        re_d     = ~bus.iWrite;
                        we_d     = bus.iWrite;
                        be_d     = lane_be(bus.iSize, bus.iAddr[1:0]);
                        baddr_d  = {bus.iAddr[31:2], 2'b00};
                        bwdata_d = lane_data(bus.iSize, bus.iWData[31:0]);
                    end
                end
            end
            StIssue: begin
                if (!write_q) begin
                    state_d = StWait;
                    cnt_d   = 2'd0;
                end else if (size_q == 2'd3 && !beat_q) begin
                    beat_d   = 1'b1;
                    we_d     = 1'b1;
                    be_d     = 4'b1111;
                    baddr_d  = baddr_q + 32'd4;
                    bwdata_d = wdata_q[63:32];
                end else begin
                    state_d = StResp;
                    done_d  = 1'b1;
                end
            end
            StWait: begin
                if (cnt_q == LastCnt) begin
                    cnt_d = 2'd0;
                    if (size_q == 2'd3 && !beat_q) begin
                        lo_d    = bus.DwReadData;
                        beat_d  = 1'b1;
                        state_d = StIssue;
                        re_d    = 1'b1;
                        be_d    = 4'b1111;
                        baddr_d = baddr_q + 32'd4;
                    end else begin
                        state_d = StResp;
                        done_d  = 1'b1;
                        rdata_d = (size_q == 2'd3) ? {bus.DwReadData, lo_q}
                                : load_extract(size_q, signed_q, addr_q[1:0], bus.DwReadData);
                    end
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q    <= StIdle;
            write_q    <= 1'b0;
            size_q     <= 2'd0;
            signed_q   <= 1'b0;
            addr_q     <= 32'd0;
            wdata_q    <= 64'd0;
            beat_q     <= 1'b0;
            cnt_q      <= 2'd0;
            lo_q       <= 32'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            misalign_q <= 1'b0;
            rdata_q    <= 64'd0;
            re_q       <= 1'b0;
            we_q       <= 1'b0;
            be_q       <= 4'b0000;
            baddr_q    <= 32'd0;
            bwdata_q   <= 32'd0;
        end else begin
            state_q    <= state_d;
            write_q    <= write_d;
            size_q     <= size_d;
            signed_q   <= signed_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            beat_q     <= beat_d;
            cnt_q      <= cnt_d;
            lo_q       <= lo_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            misalign_q <= misalign_d;
            rdata_q    <= rdata_d;
            re_q       <= re_d;
            we_q       <= we_d;
            be_q       <= be_d;
            baddr_q    <= baddr_d;
            bwdata_q   <= bwdata_d;
        end
    end

    assign bus.oBusy         = busy_q;
    assign bus.oDone         = done_q;
    assign bus.oMisalign     = misalign_q;
    assign bus.oRData        = rdata_q;
    assign bus.DwReadEnable  = re_q;
    assign bus.DwWriteEnable = we_q;
    assign bus.DwByteEnable  = be_q;
    assign bus.DwAddress     = baddr_q;
    assign bus.DwWriteData   = bwdata_q;

endmodule
